pc_next_unit: RTL and testbench
===============================

# pc_next_unit

Parametrised program-counter unit for the single-cycle core: successor to the fixed 32-bit "PC + 4 or branch" register. Holds the architectural PC and computes the next PC for sequential flow, all six RISC-V conditional branches, JAL, JALR and trap entry. Adds stall, halt/resume, a post-reset boot delay, misaligned-target detection and a redirect pulse for downstream flush. Sits between the fetch interface (drives `pc`) and the ALU/decoder (consumes compare flags and control).

## Interface
- `XLEN`, 32: PC, immediate and register width.
- `RESET_VECTOR`, 0: PC value on reset; must be 4-byte aligned.
- `BOOT_CYCLES`, 2: cycles in BOOT after reset release; legal range is 1 or more.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `stall`  in  1  hold PC this cycle.
- `halt_req`  in  1  request entry to HALTED.
- `resume`  in  1  leave HALTED.
- `branch`  in  1  conditional branch instruction.
- `branch_op`  in  3  funct3 of the branch.
- `cmp_zero`, `cmp_lt`, `cmp_ltu`  in  1 each  ALU flags: rs1==rs2, signed rs1<rs2, unsigned rs1<rs2.
- `jal`, `jalr`  in  1 each  jump controls.
- `imm`  in  XLEN  sign-extended byte offset; not shifted inside this block.
- `rs1_val`  in  XLEN  JALR base.
- `trap`  in  1  trap entry request.
- `trap_vector`  in  XLEN  trap target.
- `pc`  out  XLEN  registered current PC.
- `link_addr`  out  XLEN  combinational `pc + 4`.
- `valid`  out  1  registered; high only in RUN.
- `redirect`  out  1  registered one-cycle pulse after any non-sequential PC load.
- `misaligned`  out  1  registered one-cycle pulse on a rejected target.
- `state`  out  2  BOOT=0, RUN=1, HALTED=2.

## Operation
- Reset: `pc`=RESET_VECTOR, state BOOT, boot counter 0, `valid`/`redirect`/`misaligned`=0.
- BOOT: the counter increments each edge. On the edge where the counter equals BOOT_CYCLES-1, state becomes RUN and `valid` becomes 1. `pc` is held. `trap`, `halt_req` and `stall` are ignored.
- Branch taken, by `branch_op`:
  - 000 BEQ: `cmp_zero`
  - 001 BNE: not `cmp_zero`
  - 100 BLT: `cmp_lt`
  - 101 BGE: not `cmp_lt`
  - 110 BLTU: `cmp_ltu`
  - 111 BGEU: not `cmp_ltu`
  - 010 and 011: never taken.
- Targets:
  - branch and JAL: `pc + imm`
  - JALR: `(rs1_val + imm)` with bit 0 cleared
  - sequential: `pc + 4`
  - all sums are modulo 2^XLEN; wrap-around is silent.
- Misaligned: a selected jump or taken-branch target with bit 1 set is rejected. `pc` holds, `misaligned`=1 next cycle, `redirect`=0. Trapping is upstream's job.
- RUN priority, highest first:
  1. `trap`: `pc`=`trap_vector`, `redirect`=1.
  2. `halt_req`: go to HALTED, `pc` holds.
  3. `stall`: `pc` holds.
  4. `jalr`, then 5. `jal`, then 6. taken branch: `pc`=target, `redirect`=1.
  7. otherwise `pc`=`pc + 4`.
- HALTED: `pc` holds and `valid`=0.
  - `trap`: `pc`=`trap_vector`, `redirect`=1, state RUN.
  - else `resume`: state RUN, `pc` holds. The first update happens at the following edge.
  - `halt_req` and `resume` both high: stay HALTED.
- `trap_vector` alignment is not checked.
- Reset asserted mid-operation returns to BOOT immediately, regardless of state or pending controls.

## Timing
- `pc` updates on the rising edge after the inputs are sampled; the next-PC path is single-cycle.
- `link_addr` follows `pc` combinationally, with zero latency.
- `redirect` and `misaligned` are high for exactly one cycle, aligned with the new (or held) `pc`. They are 0 in any cycle whose edge did not generate them.
- After reset release, `valid` rises after exactly BOOT_CYCLES edges. The first `pc` change happens on edge BOOT_CYCLES+1.
- Stall and halt add no extra latency: release takes effect on the next edge.

## Test plan
- Reset with BOOT_CYCLES=2, RESET_VECTOR=0x100, then sequential run: `pc` stays 0x100 for 2 edges, `valid` rises, then 0x104, 0x108; `link_addr`=`pc+4`.
- Branch sweep from `pc`=0x200, `imm`=0x20: BEQ with `cmp_zero`=1 gives 0x220 and `redirect`=1; BNE with `cmp_zero`=1 gives 0x204; BLTU with `cmp_ltu`=1 gives 0x220; `branch_op`=010 gives 0x204.
- JALR with `rs1_val`=0x1001, `imm`=0x4: `pc`=0x1004; `rs1_val`=0x1002, `imm`=0 gives `misaligned` pulse and `pc` held.
- Wrap-around with XLEN=32: `pc`=0xFFFFFFFC sequential gives 0x0; `pc`=0x10, `imm`=-0x20 JAL gives 0xFFFFFFF0.
- Priority, all asserted together with `trap_vector`=0x80:
  - `trap`+`halt_req`+`jal`: `pc`=0x80, state RUN.
  - `stall`+`jal`: `pc` held, `redirect`=0.
- Halt/resume: `halt_req` at `pc`=0x300 gives HALTED with `valid`=0 for 3 cycles; `resume` gives RUN with `pc`=0x300, then 0x304. Reset asserted while HALTED gives BOOT with `pc`=RESET_VECTOR asynchronously.

Source files
------------

// File: rtl/pc_next_unit.sv
// pc_next_unit
//   Program-counter unit for the single-cycle core. Holds the architectural
//   PC and selects the next PC among sequential flow, the six RISC-V
//   conditional branches, JAL, JALR and trap entry. Also provides stall,
//   halt/resume, a post-reset boot delay, misaligned-target rejection and a
//   one-cycle redirect pulse for downstream flush.
//
// Parameters
//   XLEN         : PC / immediate / register width
//   RESET_VECTOR : PC value on reset (4-byte aligned)
//   BOOT_CYCLES  : edges spent in BOOT after reset release (>= 1)
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   stall               : hold PC this cycle
//   halt_req, resume    : enter / leave HALTED
//   branch, branch_op   : conditional branch and its funct3
//   cmp_zero/lt/ltu     : ALU compare flags (eq, signed lt, unsigned lt)
//   jal, jalr           : jump controls
//   imm                 : sign-extended byte offset
//   rs1_val             : JALR base
//   trap, trap_vector   : trap entry request and target
//   pc                  : registered current PC
//   link_addr           : pc + 4 (combinational)
//   valid               : registered, high only in RUN
//   redirect            : one-cycle pulse after a non-sequential PC load
//   misaligned          : one-cycle pulse after a rejected target
//   state               : BOOT=0, RUN=1, HALTED=2
module pc_next_unit #(
    parameter int unsigned XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned BOOT_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            branch,
    input  logic [2:0]      branch_op,
    input  logic            cmp_zero,
    input  logic            cmp_lt,
    input  logic            cmp_ltu,
    input  logic            jal,
    input  logic            jalr,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            trap,
    input  logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] link_addr,
    output logic            valid,
    output logic            redirect,
    output logic            misaligned,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Counter only needs to reach BOOT_CYCLES-1.
    localparam int unsigned CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    state_t            state_q;
    logic [CNT_W-1:0]  boot_cnt;
    logic [XLEN-1:0]   pc_q;

    logic              branch_taken;
    logic [XLEN-1:0]   seq_pc;
    logic [XLEN-1:0]   rel_target;
    logic [XLEN-1:0]   jalr_sum;
    logic [XLEN-1:0]   jalr_target;
    logic              jump_sel;
    logic [XLEN-1:0]   jump_target;

    // Branch condition decode from funct3; 010/011 are never taken.
    always_comb begin
        branch_taken = 1'b0;
        case (branch_op)
            3'b000:  branch_taken = cmp_zero;
            3'b001:  branch_taken = ~cmp_zero;
            3'b100:  branch_taken = cmp_lt;
            3'b101:  branch_taken = ~cmp_lt;
            3'b110:  branch_taken = cmp_ltu;
            3'b111:  branch_taken = ~cmp_ltu;
            default: branch_taken = 1'b0;
        endcase
    end

    // Target arithmetic; all sums wrap modulo 2^XLEN.
    always_comb begin
        seq_pc      = pc_q + XLEN'(4);
        rel_target  = pc_q + imm;
        jalr_sum    = rs1_val + imm;
        jalr_target = {jalr_sum[XLEN-1:1], 1'b0};
        jump_sel    = 1'b0;
        jump_target = seq_pc;
        if (jalr) begin
            jump_sel    = 1'b1;
            jump_target = jalr_target;
        end else if (jal) begin
            jump_sel    = 1'b1;
            jump_target = rel_target;
        end else if (branch && branch_taken) begin
            jump_sel    = 1'b1;
            jump_target = rel_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_BOOT;
            boot_cnt   <= '0;
            pc_q       <= RESET_VECTOR;
            valid      <= 1'b0;
            redirect   <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            // Pulses are cleared unless this edge generates them.
            redirect   <= 1'b0;
            misaligned <= 1'b0;
            case (state_q)
                ST_BOOT: begin
                    boot_cnt <= boot_cnt + CNT_W'(1);
                    if (boot_cnt == BOOT_LAST) begin
                        state_q <= ST_RUN;
                        valid   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    valid <= 1'b1;
                    if (trap) begin
                        pc_q     <= trap_vector;
                        redirect <= 1'b1;
                    end else if (halt_req) begin
                        state_q <= ST_HALTED;
                        valid   <= 1'b0;
                    end else if (stall) begin
                        pc_q <= pc_q;
                    end else if (jump_sel) begin
                        // A target with bit 1 set is rejected: PC holds.
                        if (jump_target[1]) begin
                            misaligned <= 1'b1;
                        end else begin
                            pc_q     <= jump_target;
                            redirect <= 1'b1;
                        end
                    end else begin
                        pc_q <= seq_pc;
                    end
                end
                ST_HALTED: begin
                    if (trap) begin
                        pc_q     <= trap_vector;
                        redirect <= 1'b1;
                        state_q  <= ST_RUN;
                        valid    <= 1'b1;
                    end else if (resume && !halt_req) begin
                        state_q <= ST_RUN;
                        valid   <= 1'b1;
                    end else begin
                        valid <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_BOOT;
                    valid   <= 1'b0;
                end
            endcase
        end
    end

    assign pc        = pc_q;
    assign link_addr = seq_pc;
    assign state     = state_q;

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            reset;
    logic            stall;
    logic            halt_req;
    logic            resume;
    logic            branch;
    logic [2:0]      branch_op;
    logic            cmp_zero;
    logic            cmp_lt;
    logic            cmp_ltu;
    logic            jal;
    logic            jalr;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val;
    logic            trap;
    logic [XLEN-1:0] trap_vector;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] link_addr;
    logic            valid;
    logic            redirect;
    logic            misaligned;
    logic [1:0]      state;

    int total = 0;
    int bad   = 0;

    pc_next_unit #(
        .XLEN(32),
        .RESET_VECTOR(32'h100),
        .BOOT_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req),
        .resume(resume), .branch(branch), .branch_op(branch_op),
        .cmp_zero(cmp_zero), .cmp_lt(cmp_lt), .cmp_ltu(cmp_ltu),
        .jal(jal), .jalr(jalr), .imm(imm), .rs1_val(rs1_val),
        .trap(trap), .trap_vector(trap_vector), .pc(pc),
        .link_addr(link_addr), .valid(valid), .redirect(redirect),
        .misaligned(misaligned), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        stall = 0; halt_req = 0; resume = 0; branch = 0; branch_op = 3'b000;
        cmp_zero = 0; cmp_lt = 0; cmp_ltu = 0; jal = 0; jalr = 0;
        imm = '0; rs1_val = '0; trap = 0; trap_vector = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Uses a trap to place the PC at an arbitrary address.
    task automatic set_pc(input logic [XLEN-1:0] addr);
        clear_inputs();
        trap = 1; trap_vector = addr;
        step();
        clear_inputs();
        total++;
        if (pc !== addr || redirect !== 1'b1) begin
            bad++;
            $display("FAIL set_pc: pc=%h redirect=%b required pc=%h redirect=1", pc, redirect, addr);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        step();
        total++;
        if (pc !== 32'h100 || state !== 2'd0 || valid !== 0 || redirect !== 0 || misaligned !== 0) begin
            bad++;
            $display("FAIL reset: pc=%h state=%0d valid=%b required pc=100 state=0 valid=0", pc, state, valid);
        end
        reset = 0;
        step();
        total++;
        if (pc !== 32'h100 || state !== 2'd0 || valid !== 0) begin
            bad++;
            $display("FAIL boot_edge1: pc=%h state=%0d valid=%b required pc=100 state=0 valid=0", pc, state, valid);
        end
        step();
        total++;
        if (pc !== 32'h100 || state !== 2'd1 || valid !== 1) begin
            bad++;
            $display("FAIL boot_edge2: pc=%h state=%0d valid=%b required pc=100 state=1 valid=1", pc, state, valid);
        end
    endtask

    task automatic test_sequential();
        logic [XLEN-1:0] exp_pc [2] = '{32'h104, 32'h108};
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (pc !== exp_pc[i] || link_addr !== exp_pc[i] + 32'd4 || redirect !== 0) begin
                bad++;
                $display("FAIL seq%0d: pc=%h link=%h redirect=%b required pc=%h link=%h redirect=0",
                         i, pc, link_addr, redirect, exp_pc[i], exp_pc[i] + 32'd4);
            end
        end
    endtask

    task automatic test_branches();
        // op, cmp_zero, cmp_lt, cmp_ltu, expected pc, expected redirect
        logic [2:0]      ops  [6] = '{3'b000, 3'b001, 3'b110, 3'b010, 3'b101, 3'b100};
        logic [2:0]      flg  [6] = '{3'b100, 3'b100, 3'b001, 3'b111, 3'b000, 3'b000};
        logic [XLEN-1:0] epc  [6] = '{32'h220, 32'h204, 32'h220, 32'h204, 32'h220, 32'h204};
        logic            ered [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            set_pc(32'h200);
            branch = 1; branch_op = ops[i]; imm = 32'h20;
            cmp_zero = flg[i][2]; cmp_lt = flg[i][1]; cmp_ltu = flg[i][0];
            step();
            clear_inputs();
            total++;
            if (pc !== epc[i] || redirect !== ered[i]) begin
                bad++;
                $display("FAIL branch%0d op=%b: pc=%h redirect=%b required pc=%h redirect=%b",
                         i, ops[i], pc, redirect, epc[i], ered[i]);
            end
        end
    endtask

    task automatic test_jalr();
        set_pc(32'h400);
        jalr = 1; rs1_val = 32'h1001; imm = 32'h4;
        step();
        total++;
        if (pc !== 32'h1004 || redirect !== 1 || misaligned !== 0) begin
            bad++;
            $display("FAIL jalr: pc=%h redirect=%b required pc=1004 redirect=1", pc, redirect);
        end
        rs1_val = 32'h1002; imm = 32'h0;
        step();
        total++;
        if (pc !== 32'h1004 || misaligned !== 1 || redirect !== 0) begin
            bad++;
            $display("FAIL jalr_misaligned: pc=%h mis=%b redirect=%b required pc=1004 mis=1 redirect=0",
                     pc, misaligned, redirect);
        end
        clear_inputs();
        step();
        total++;
        if (pc !== 32'h1008 || misaligned !== 0) begin
            bad++;
            $display("FAIL mis_pulse_end: pc=%h mis=%b required pc=1008 mis=0", pc, misaligned);
        end
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        step();
        total++;
        if (pc !== 32'h0 || link_addr !== 32'h4) begin
            bad++;
            $display("FAIL wrap_seq: pc=%h link=%h required pc=0 link=4", pc, link_addr);
        end
        set_pc(32'h10);
        jal = 1; imm = 32'hFFFF_FFE0;
        step();
        clear_inputs();
        total++;
        if (pc !== 32'hFFFF_FFF0 || redirect !== 1) begin
            bad++;
            $display("FAIL wrap_jal: pc=%h redirect=%b required pc=fffffff0 redirect=1", pc, redirect);
        end
    endtask

    task automatic test_priority();
        set_pc(32'h500);
        trap = 1; halt_req = 1; jal = 1; imm = 32'h40; trap_vector = 32'h80;
        step();
        clear_inputs();
        total++;
        if (pc !== 32'h80 || state !== 2'd1 || redirect !== 1) begin
            bad++;
            $display("FAIL prio_trap: pc=%h state=%0d redirect=%b required pc=80 state=1 redirect=1",
                     pc, state, redirect);
        end
        stall = 1; jal = 1; imm = 32'h40;
        step();
        clear_inputs();
        total++;
        if (pc !== 32'h80 || redirect !== 0 || state !== 2'd1) begin
            bad++;
            $display("FAIL prio_stall: pc=%h redirect=%b required pc=80 redirect=0", pc, redirect);
        end
        step();
        total++;
        if (pc !== 32'h84) begin
            bad++;
            $display("FAIL stall_release: pc=%h required pc=84", pc);
        end
    endtask

    task automatic test_halt_resume();
        set_pc(32'h300);
        halt_req = 1;
        step();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (pc !== 32'h300 || state !== 2'd2 || valid !== 0) begin
                bad++;
                $display("FAIL halted%0d: pc=%h state=%0d valid=%b required pc=300 state=2 valid=0",
                         i, pc, state, valid);
            end
            if (i < 2) step();
        end
        halt_req = 1; resume = 1;
        step();
        total++;
        if (state !== 2'd2 || pc !== 32'h300) begin
            bad++;
            $display("FAIL halt_and_resume: state=%0d pc=%h required state=2 pc=300", state, pc);
        end
        clear_inputs();
        resume = 1;
        step();
        clear_inputs();
        total++;
        if (pc !== 32'h300 || state !== 2'd1 || valid !== 1) begin
            bad++;
            $display("FAIL resume: pc=%h state=%0d valid=%b required pc=300 state=1 valid=1", pc, state, valid);
        end
        step();
        total++;
        if (pc !== 32'h304) begin
            bad++;
            $display("FAIL after_resume: pc=%h required pc=304", pc);
        end
    endtask

    task automatic test_reset_in_halt();
        halt_req = 1;
        step();
        clear_inputs();
        total++;
        if (state !== 2'd2) begin
            bad++;
            $display("FAIL halt_again: state=%0d required state=2", state);
        end
        #2 reset = 1;
        #1;
        total++;
        if (pc !== 32'h100 || state !== 2'd0 || valid !== 0) begin
            bad++;
            $display("FAIL async_reset: pc=%h state=%0d valid=%b required pc=100 state=0 valid=0", pc, state, valid);
        end
        step();
        reset = 0;
        step();
        step();
        total++;
        if (state !== 2'd1 || valid !== 1 || pc !== 32'h100) begin
            bad++;
            $display("FAIL reboot: pc=%h state=%0d valid=%b required pc=100 state=1 valid=1", pc, state, valid);
        end
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_branches();
        test_jalr();
        test_wrap();
        test_priority();
        test_halt_resume();
        test_reset_in_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
